// File: rtl/snn_fp16_pkg.sv
// Shared fp16 constants and the rate-decoder state type for the SNN datapath.
package snn_fp16_pkg;

  localparam int FP16_W      = 16;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ACCUM,
    LOAD,
    PRESENT
  } rd_state_t;

endpackage

// File: rtl/uint_to_fp16.sv
// Exact unsigned-integer to fp16 conversion (leading-one detect + normalise).
// EXP_OFF shifts the exponent, e.g. -WIN_LOG2 to divide by the window length.
module uint_to_fp16
  import snn_fp16_pkg::*;
#(
  parameter int IN_W    = 5,
  parameter int EXP_OFF = 0
) (
  input  logic [IN_W-1:0]   val,
  output logic [FP16_W-1:0] fp
);

  localparam logic [FP16_EXP_W-1:0] EXP_BASE = FP16_EXP_W'(FP16_BIAS + EXP_OFF);

  logic [FP16_EXP_W-1:0]  lead;
  logic [FP16_MANT_W-1:0] mant;

  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (val[i]) lead = FP16_EXP_W'(i);
    end
    // Bits below the leading one land in the 10-bit fraction; the hidden one drops out.
    mant = FP16_MANT_W'({val, {FP16_MANT_W{1'b0}}} >> lead);
    fp   = (val == '0) ? FP16_ZERO : {1'b0, EXP_BASE + lead, mant};
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Per-channel spike counter over a 2^WIN_LOG2 window, drained as one fp16 value per channel.
// Define RATE_NORM_EN to output the firing rate c/2^WIN_LOG2 instead of the raw count.
module spike_rate_decoder
  import snn_fp16_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int WIN_LOG2 = 4,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spk_valid,
  output logic                    spk_ready,
  input  logic [N_CH-1:0]         spk,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    out_last
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [WIN_LOG2-1:0] T_LAST  = '1;
  localparam logic [CH_W-1:0]     CH_LAST = CH_W'(N_CH - 1);
`ifdef RATE_NORM_EN
  localparam int EXP_OFF = -WIN_LOG2;
`else
  localparam int EXP_OFF = 0;
`endif

  rd_state_t         state_reg, state_next;
  logic [WIN_LOG2-1:0] t_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [CNT_W-1:0]  cnt_reg [N_CH];
  logic [FP16_W-1:0] fp_val;
  logic              accept, drain_step, drain_done;

  assign spk_ready  = (state_reg == ACCUM) & ~rst;
  assign out_valid  = (state_reg == PRESENT);
  assign accept     = spk_valid & spk_ready;
  assign drain_step = out_valid & out_ready;
  assign drain_done = drain_step & (ch_reg == CH_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ACCUM;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && t_reg == T_LAST) state_next = LOAD;
      LOAD:    state_next = PRESENT;
      PRESENT: if (drain_step) state_next = drain_done ? ACCUM : LOAD;
      default: state_next = ACCUM;
    endcase
  end

  // Counters clear on the final drain handshake so the next window starts from zero.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || drain_done)        cnt_reg[gi] <= '0;
      else if (accept && spk[gi])   cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
    end
  end

  // t wraps to zero naturally when the last timestep of the window is accepted.
  always_ff @(posedge clk) begin
    if (rst)         t_reg <= '0;
    else if (accept) t_reg <= t_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)             ch_reg <= '0;
    else if (drain_step) ch_reg <= drain_done ? '0 : ch_reg + 1'b1;
  end

  uint_to_fp16 #(
    .IN_W    (CNT_W),
    .EXP_OFF (EXP_OFF)
  ) u_conv (
    .val (cnt_reg[ch_reg]),
    .fp  (fp_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= FP16_ZERO;
      out_ch   <= '0;
      out_last <= 1'b0;
    end else if (state_reg == LOAD) begin
      out_data <= fp_val;
      out_ch   <= ch_reg;
      out_last <= (ch_reg == CH_LAST);
    end
  end

endmodule
